windower_stream: RTL and testbench



---
 rtl/windower_stream.sv | 187 ++++++++++++++++++
 tb/tb_windower_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windower_stream.sv
// -----------------------------------------------------------------------------
// windower_stream
//
// Streaming 1-D sliding-window generator. Accepts a frame of NO_CH-bit samples,
// THROUGHPUT samples per beat, and emits one WINDOW-tap window per beat. When
// PADDING is set, (WINDOW-1)/2 zero samples are added at each end of the frame.
// Both sides use valid/ready handshakes. Input is stalled while the trailing
// pad is flushed out.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_vld/in_rdy input beat handshake (in_rdy is combinational)
//   data_in       THROUGHPUT samples, index 0 = newest
//   frame_len     frame length in beats, sampled on the first beat of a frame
//   out_vld/rdy   output window handshake
//   data_out      WINDOW taps, tap 0 = newest sample
//   out_first     first window of the frame
//   out_last      last window of the frame
//   busy          a frame is in progress
// -----------------------------------------------------------------------------
module windower_stream #(
    parameter int NO_CH        = 2,
    parameter int THROUGHPUT   = 1,
    parameter int WINDOW       = 3,
    parameter int PADDING      = 1,
    parameter int MAX_LEN_LOG2 = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [NO_CH*THROUGHPUT-1:0] data_in,
    input  logic [MAX_LEN_LOG2-1:0]     frame_len,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [NO_CH*WINDOW-1:0]     data_out,
    output logic                        out_first,
    output logic                        out_last,
    output logic                        busy
);

    localparam int PAD       = (PADDING != 0) ? (WINDOW - 1) / 2 : 0;
    localparam int PAD_BEATS = (PAD + THROUGHPUT - 1) / THROUGHPUT;
    localparam int TW        = NO_CH * WINDOW;
    localparam int BW        = NO_CH * THROUGHPUT;
    localparam int CW        = MAX_LEN_LOG2 + 1;

    localparam logic [CW-1:0] PB_C        = CW'(PAD_BEATS);
    localparam logic [CW-1:0] PB_LAST_C   = CW'(PAD_BEATS - 1);
    // Beat index at which a frame is forced to end, so an illegal frame_len
    // cannot keep the block out of IDLE forever.
    localparam logic [CW-1:0] CNT_GUARD_C = CW'((1 << MAX_LEN_LOG2) - 1);
    localparam bit            NO_PAD      = (PAD_BEATS == 0);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t                  state_q;
    logic [TW-1:0]           taps_q;
    logic                    vld_q;
    logic                    first_q;
    logic                    last_q;
    logic [MAX_LEN_LOG2-1:0] len_q;
    logic [CW-1:0]           beat_cnt_q;   // index of the next input beat
    logic [CW-1:0]           flush_cnt_q;

    logic          slot_free;
    logic          accept;
    logic          last_in;
    logic [CW-1:0] len_m1;
    logic [TW-1:0] beat_d;    // new beat in the low taps, zeros above
    logic [TW-1:0] flush_d;   // taps shifted up, zeros shifted in
    logic [TW-1:0] shift_d;   // taps shifted up, new beat shifted in

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        beat_d           = '0;
        beat_d[BW-1:0]   = data_in;
        flush_d          = taps_q << BW;
        shift_d          = flush_d | beat_d;
    end

    assign slot_free = !vld_q || out_rdy;
    assign in_rdy    = slot_free && (state_q != FLUSH);
    assign accept    = in_vld && in_rdy;
    assign len_m1    = {1'b0, len_q} - CW'(1);
    assign last_in   = (beat_cnt_q == len_m1) || (beat_cnt_q == CNT_GUARD_C);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    // NOTE: the tap register is the output register and is small, so it is
    // reset along with the control state (output reads as zero after reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            vld_q       <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            // A handed-off window drops out unless a new one is emitted below.
            if (out_rdy) begin
                vld_q   <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        len_q       <= frame_len;
                        beat_cnt_q  <= CW'(1);
                        flush_cnt_q <= '0;
                        // Leading pad: everything but the new beat is zero.
                        taps_q      <= beat_d;
                        if (NO_PAD) begin
                            vld_q   <= 1'b1;
                            first_q <= 1'b1;
                            last_q  <= (frame_len == MAX_LEN_LOG2'(1));
                            state_q <= (frame_len == MAX_LEN_LOG2'(1)) ? IDLE : RUN;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        taps_q     <= shift_d;
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                        if (beat_cnt_q == PB_C) begin
                            vld_q   <= 1'b1;
                            first_q <= 1'b1;
                            last_q  <= 1'b0;
                            // A frame of PAD_BEATS+1 beats ends on this beat.
                            state_q <= last_in ? FLUSH : RUN;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        taps_q     <= shift_d;
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                        vld_q      <= 1'b1;
                        first_q    <= 1'b0;
                        last_q     <= NO_PAD && last_in;
                        if (last_in) begin
                            state_q <= NO_PAD ? IDLE : FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (slot_free) begin
                        taps_q      <= flush_d;
                        flush_cnt_q <= flush_cnt_q + CW'(1);
                        vld_q       <= 1'b1;
                        first_q     <= 1'b0;
                        if (flush_cnt_q == PB_LAST_C || NO_PAD) begin
                            last_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            last_q  <= 1'b0;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_vld   = vld_q;
    assign data_out  = taps_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_windower_stream.sv
// -----------------------------------------------------------------------------
// tb_windower_stream
//
// Three instances of windower_stream (4-bit samples):
//   u0: THROUGHPUT=1, WINDOW=3, PADDING=1 (PAD_BEATS=1)
//   u1: THROUGHPUT=2, WINDOW=5, PADDING=1 (PAD_BEATS=1)
//   u2: THROUGHPUT=1, WINDOW=3, PADDING=0 (PAD_BEATS=0)
// Expected windows come from a zero-extended sample sequence: window j of a
// frame ends at sample time (j+PAD_BEATS+1)*T-1 and tap k reads the sample
// k steps earlier, or 0 outside the frame.
// -----------------------------------------------------------------------------
module tb_windower_stream;

    localparam int NC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_vld;
    logic [2:0] out_rdy;
    logic [7:0] din;
    logic [9:0] flen;
    wire  [2:0] in_rdy, out_vld, out_first, out_last, busy;
    wire  [11:0] dout0, dout2;
    wire  [19:0] dout1;

    int vectors     = 0;
    int miscompares = 0;

    int         smp   [0:4095];
    int         lens  [0:63];
    int         nfr;
    logic [19:0] exp_d [0:1023];
    bit         exp_f [0:1023];
    bit         exp_l [0:1023];
    int         n_exp;

    always #5 clk = ~clk;

    windower_stream #(.NO_CH(4), .THROUGHPUT(1), .WINDOW(3), .PADDING(1), .MAX_LEN_LOG2(10)) u0 (
        .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .data_in(din[3:0]),
        .frame_len(flen), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .data_out(dout0),
        .out_first(out_first[0]), .out_last(out_last[0]), .busy(busy[0]));

    windower_stream #(.NO_CH(4), .THROUGHPUT(2), .WINDOW(5), .PADDING(1), .MAX_LEN_LOG2(10)) u1 (
        .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .data_in(din),
        .frame_len(flen), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .data_out(dout1),
        .out_first(out_first[1]), .out_last(out_last[1]), .busy(busy[1]));

    windower_stream #(.NO_CH(4), .THROUGHPUT(1), .WINDOW(3), .PADDING(0), .MAX_LEN_LOG2(10)) u2 (
        .clk(clk), .rst(rst), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]), .data_in(din[3:0]),
        .frame_len(flen), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]), .data_out(dout2),
        .out_first(out_first[2]), .out_last(out_last[2]), .busy(busy[2]));

    function automatic int cfg_t(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    function automatic int cfg_w(input int id);
        return (id == 1) ? 5 : 3;
    endfunction

    function automatic int cfg_pb(input int id);
        return (id == 2) ? 0 : 1;
    endfunction

    function automatic logic [19:0] get_dout(input int id);
        case (id)
            0:       return {8'b0, dout0};
            1:       return dout1;
            default: return {8'b0, dout2};
        endcase
    endfunction

    function automatic logic [19:0] model_win(input int id, input int off, input int len, input int j);
        int tt = cfg_t(id);
        int t;
        logic [19:0] r = '0;
        for (int k = 0; k < cfg_w(id); k++) begin
            t = (j + cfg_pb(id) + 1) * tt - 1 - k;
            if (t >= 0 && t < len * tt) r[k*NC +: NC] = 4'(smp[off + t]);
        end
        return r;
    endfunction

    task automatic build_expected(input int id);
        int off = 0;
        n_exp = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int j = 0; j < lens[f]; j++) begin
                exp_d[n_exp] = model_win(id, off, lens[f], j);
                exp_f[n_exp] = (j == 0);
                exp_l[n_exp] = (j == lens[f] - 1);
                n_exp++;
            end
            off += lens[f] * cfg_t(id);
        end
    endtask

    task automatic make_frames(input int id, input int n, input int lo, input int hi);
        int off = 0;
        nfr = n;
        for (int f = 0; f < n; f++) begin
            lens[f] = $urandom_range(hi, lo);
            for (int s = 0; s < lens[f] * cfg_t(id); s++) smp[off + s] = $urandom_range(15, 0);
            off += lens[f] * cfg_t(id);
        end
    endtask

    // Streams the frames in lens/smp through instance id and scores every
    // handed-off window in order. rdy_mode: 0 = always ready, 1 = random,
    // 2 = repeating 1,0,0,1 pattern.
    task automatic run_stream(input int id, input int rdy_mode, input int vld_rand,
                              output int rdy_low, output int first_lat);
        int tt = cfg_t(id);
        int total = 0, beat = 0, fr = 0, fbeat = 0, got = 0, cyc = 0, acc0 = -1;
        bit stalled = 1'b0;
        logic [19:0] held = '0;
        logic [19:0] d;
        rdy_low   = 0;
        first_lat = -1;
        for (int f = 0; f < nfr; f++) total += lens[f];
        build_expected(id);
        while (got < n_exp && cyc < 4000) begin
            in_vld[id] = (beat < total) && (vld_rand == 0 || $urandom_range(3, 0) != 0);
            din = '0;
            if (beat < total)
                for (int s = 0; s < tt; s++) din[s*NC +: NC] = 4'(smp[beat*tt + tt - 1 - s]);
            flen = (fr < nfr) ? 10'(lens[fr]) : 10'd0;
            case (rdy_mode)
                0:       out_rdy[id] = 1'b1;
                1:       out_rdy[id] = 1'($urandom_range(1, 0));
                default: out_rdy[id] = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(negedge clk);
            d = get_dout(id);
            if (stalled) begin
                vectors++;
                if (out_vld[id] !== 1'b1 || d !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold u%0d win%0d: vld=%b data=%h required vld=1 data=%h",
                             id, got, out_vld[id], d, held);
                end
            end
            if (in_rdy[id] === 1'b0) rdy_low++;
            if (out_vld[id] === 1'b1 && out_rdy[id]) begin
                if (first_lat < 0) first_lat = cyc - acc0;
                vectors++;
                if (d !== exp_d[got] || out_first[id] !== exp_f[got] || out_last[id] !== exp_l[got]) begin
                    miscompares++;
                    $display("FAIL window u%0d win%0d: data=%h first=%b last=%b required data=%h first=%b last=%b",
                             id, got, d, out_first[id], out_last[id], exp_d[got], exp_f[got], exp_l[got]);
                end
                got++;
            end
            stalled = (out_vld[id] === 1'b1) && !out_rdy[id];
            held    = d;
            if (in_vld[id] && in_rdy[id] === 1'b1) begin
                if (acc0 < 0) acc0 = cyc;
                beat++;
                fbeat++;
                if (fbeat == lens[fr]) begin
                    fr++;
                    fbeat = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_vld[id]  = 1'b0;
        out_rdy[id] = 1'b1;
        vectors++;
        if (got < n_exp) begin
            miscompares++;
            $display("FAIL timeout u%0d: got %0d windows, required %0d", id, got, n_exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        for (int id = 0; id < 3; id++) begin
            vectors++;
            if (out_vld[id] !== 1'b0 || out_first[id] !== 1'b0 || out_last[id] !== 1'b0 ||
                busy[id] !== 1'b0 || get_dout(id) !== 20'h0 || in_rdy[id] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset u%0d: vld=%b first=%b last=%b busy=%b data=%h in_rdy=%b required 0,0,0,0,0,1",
                         id, out_vld[id], out_first[id], out_last[id], busy[id], get_dout(id), in_rdy[id]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_scenario1;
        nfr     = 1;
        lens[0] = 4;
        for (int i = 0; i < 4; i++) smp[i] = i + 1;
    endtask

    task automatic test_basic;
        int rl, lat;
        load_scenario1();
        run_stream(0, 0, 0, rl, lat);
        vectors++;
        if (rl !== 1) begin
            miscompares++;
            $display("FAIL basic_flush_stall: in_rdy low %0d cycles, required 1", rl);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL basic_latency: first window after %0d cycles, required 2", lat);
        end
    endtask

    task automatic test_backpressure;
        int rl, lat;
        load_scenario1();
        run_stream(0, 2, 0, rl, lat);
    endtask

    task automatic test_back_to_back;
        int rl, lat;
        nfr     = 2;
        lens[0] = 4;
        lens[1] = 4;
        for (int i = 0; i < 8; i++) smp[i] = i + 1;
        run_stream(0, 0, 0, rl, lat);
        vectors++;
        if (rl !== 2) begin
            miscompares++;
            $display("FAIL b2b_bubbles: in_rdy low %0d cycles, required 2", rl);
        end
    endtask

    task automatic test_throughput2;
        int rl, lat;
        nfr     = 1;
        lens[0] = 3;
        for (int i = 0; i < 6; i++) smp[i] = $urandom_range(15, 1);
        run_stream(1, 0, 0, rl, lat);
    endtask

    task automatic test_no_pad;
        int rl, lat;
        nfr     = 1;
        lens[0] = 3;
        for (int i = 0; i < 3; i++) smp[i] = $urandom_range(15, 1);
        run_stream(2, 0, 0, rl, lat);
        vectors++;
        if (rl !== 0 || lat !== 1) begin
            miscompares++;
            $display("FAIL no_pad: in_rdy low %0d cycles latency %0d, required 0 and 1", rl, lat);
        end
    endtask

    task automatic test_reset_flush;
        int rl, lat;
        int beat = 0;
        bit hit  = 1'b0;
        load_scenario1();
        for (int c = 0; c < 20 && !hit; c++) begin
            in_vld[0]  = (beat < 4);
            din        = (beat < 4) ? 8'(smp[beat]) : 8'h0;
            flen       = 10'd4;
            out_rdy[0] = 1'b1;
            @(negedge clk);
            if (busy[0] === 1'b1 && in_rdy[0] === 1'b0 && out_vld[0] === 1'b1) begin
                hit = 1'b1;
            end else begin
                if (in_vld[0] && in_rdy[0] === 1'b1) beat++;
                @(posedge clk);
                #1;
            end
        end
        in_vld[0] = 1'b0;
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reach_flush: flush state with valid output not observed, required within 20 cycles");
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (out_vld[0] !== 1'b0 || busy[0] !== 1'b0 || dout0 !== 12'h0) begin
            miscompares++;
            $display("FAIL async_reset: vld=%b busy=%b data=%h required 0,0,0", out_vld[0], busy[0], dout0);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_stream(0, 0, 0, rl, lat);
        vectors++;
        if (rl !== 1) begin
            miscompares++;
            $display("FAIL post_reset_flush: in_rdy low %0d cycles, required 1", rl);
        end
    endtask

    task automatic test_random;
        int rl, lat;
        for (int r = 0; r < 3; r++) begin
            make_frames(0, 6, 2, 10);
            run_stream(0, 1, 1, rl, lat);
            make_frames(1, 4, 2, 6);
            run_stream(1, 1, 1, rl, lat);
            make_frames(2, 6, 1, 6);
            run_stream(2, 1, 1, rl, lat);
        end
        for (int id = 0; id < 3; id++) begin
            @(negedge clk);
            vectors++;
            if (busy[id] !== 1'b0 || out_vld[id] !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after u%0d: busy=%b vld=%b required 0,0", id, busy[id], out_vld[id]);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = '1;
        din     = '0;
        flen    = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_throughput2();
        test_no_pad();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
